// File: rtl/timing_nco_if.sv
// timing_nco_if: sample/control inputs and strobe outputs of the timing-recovery NCO.
// The master side (loop filter / sample source) drives samples and control.
// The slave side (the NCO) returns strobe, symbol phase, mu and clamp status.
interface timing_nco_if #(
    parameter int WERR = 18,
    parameter int WMU  = 16
);
    logic                   sample_val_i;
    logic signed [WERR-1:0] ctrl_i;
    logic                   ctrl_val_i;
    logic                   strobe_o;
    logic                   sym_o;
    logic [WMU-1:0]         mu_o;
    logic                   clamp_o;

    modport master (
        output sample_val_i, ctrl_i, ctrl_val_i,
        input  strobe_o, sym_o, mu_o, clamp_o
    );

    modport slave (
        input  sample_val_i, ctrl_i, ctrl_val_i,
        output strobe_o, sym_o, mu_o, clamp_o
    );
endinterface

// File: rtl/timing_nco.sv
// timing_nco: modulo-1 decrementing NCO for Gardner timing recovery.
// It decrements once per input sample at twice the symbol rate. Each underflow
// emits an interpolation strobe with the fractional interval mu. Successive
// strobes alternate between on-time (sym_o=1) and midpoint (sym_o=0).
// Optional feature: define TIMING_NCO_CLAMP_EN to saturate the step to
// NOM_STEP +/- NOM_STEP/8 and report saturation on clamp_o. Without it the
// step is used as-is and clamp_o is always 0.
module timing_nco #(
    parameter int WERR       = 18,
    parameter int WACC       = 24,
    parameter int SPS_LOG2   = 3,
    parameter int NOM_STEP   = 2 ** (WACC + 1 - SPS_LOG2),
    parameter int CTRL_SHIFT = 3,
    parameter int WMU        = 16
) (
    input  logic       clk,
    input  logic       reset,
    timing_nco_if.slave nco
);

    localparam int WSTEP = WACC + 2;
    localparam int MU_SH = SPS_LOG2 - 1;
    localparam logic signed [WSTEP-1:0] NOM_STEP_S = WSTEP'(NOM_STEP);

    logic [WACC-1:0]         eta_q, eta_d;
    logic signed [WERR-1:0]  ctrl_q, ctrl_d;
    logic                    flag_q, flag_d;
    logic                    strobe_q, strobe_d;
    logic                    sym_q, sym_d;
    logic [WMU-1:0]          mu_q, mu_d;
    logic                    clamp_q, clamp_d;

    logic signed [WSTEP-1:0] ctrlExt;
    logic signed [WSTEP-1:0] stepRaw;
    logic signed [WSTEP-1:0] step;
    logic signed [WSTEP-1:0] etaExt;
    logic                    clampHit;
    logic                    underflow;
    logic                    muOverflow;
    logic [WMU-1:0]          muNext;

    // Build the per-sample step from the registered loop-filter correction, optionally saturated
    always_comb begin
        ctrlExt  = {{(WSTEP-WERR){ctrl_q[WERR-1]}}, ctrl_q};
        stepRaw  = NOM_STEP_S + (ctrlExt <<< CTRL_SHIFT);
        step     = stepRaw;
        clampHit = 1'b0;
`ifdef TIMING_NCO_CLAMP_EN
        if (stepRaw < WSTEP'(NOM_STEP - NOM_STEP / 8)) begin
            step     = WSTEP'(NOM_STEP - NOM_STEP / 8);
            clampHit = 1'b1;
        end else if (stepRaw > WSTEP'(NOM_STEP + NOM_STEP / 8)) begin
            step     = WSTEP'(NOM_STEP + NOM_STEP / 8);
            clampHit = 1'b1;
        end
`endif
    end

    // Underflow test and mu extraction; mu is old eta scaled by 2^(SPS_LOG2-1), saturating
    always_comb begin
        etaExt     = signed'({{(WSTEP-WACC){1'b0}}, eta_q});
        underflow  = (step > etaExt);
        muOverflow = |eta_q[WACC-1 -: MU_SH];
        muNext     = muOverflow ? {WMU{1'b1}} : eta_q[WACC-1-MU_SH -: WMU];
    end

    // Next-state logic: control capture, eta decrement and strobe generation per sample
    always_comb begin
        eta_d    = eta_q;
        ctrl_d   = ctrl_q;
        flag_d   = flag_q;
        strobe_d = 1'b0;
        sym_d    = sym_q;
        mu_d     = mu_q;
        clamp_d  = clamp_q;
        if (nco.ctrl_val_i) begin
            ctrl_d = nco.ctrl_i;
        end
        if (nco.sample_val_i) begin
            eta_d   = eta_q - step[WACC-1:0];
            clamp_d = clampHit;
            if (underflow) begin
                strobe_d = 1'b1;
                flag_d   = ~flag_q;
                sym_d    = ~flag_q;
                mu_d     = muNext;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            eta_q    <= '1;
            ctrl_q   <= '0;
            flag_q   <= 1'b0;
            strobe_q <= 1'b0;
            sym_q    <= 1'b0;
            mu_q     <= '0;
            clamp_q  <= 1'b0;
        end else begin
            eta_q    <= eta_d;
            ctrl_q   <= ctrl_d;
            flag_q   <= flag_d;
            strobe_q <= strobe_d;
            sym_q    <= sym_d;
            mu_q     <= mu_d;
            clamp_q  <= clamp_d;
        end
    end

    assign nco.strobe_o = strobe_q;
    assign nco.sym_o    = sym_q;
    assign nco.mu_o     = mu_q;
    assign nco.clamp_o  = clamp_q;

endmodule

// File: tb/tb_timing_nco.sv
// tb_timing_nco: directed, self-checking bench for timing_nco.
// Each tick drives inputs, waits for the clock edge and checks the registered
// outputs 1 ns later. Expected values are hand-computed for WACC=24, SPS=8.
// Clamp behaviour is checked according to TIMING_NCO_CLAMP_EN.
module tb_timing_nco;

    localparam int WERR = 18;
    localparam int WMU  = 16;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    timing_nco_if #(.WERR(WERR), .WMU(WMU)) bus ();

    timing_nco #(.WERR(WERR), .WMU(WMU)) dut (
        .clk   (clk),
        .reset (reset),
        .nco   (bus.slave)
    );

    // Free-running clock, 10 ns period
    always #5 clk = ~clk;

    task automatic tick(input logic sv, input logic cv, input int c);
        bus.sample_val_i = sv;
        bus.ctrl_val_i   = cv;
        bus.ctrl_i       = WERR'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick(1'b0, 1'b0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        vectors++;
        if (bus.strobe_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_strobe: got %b want 0", bus.strobe_o); end
        vectors++;
        if (bus.sym_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sym: got %b want 0", bus.sym_o); end
        vectors++;
        if (bus.mu_o !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_mu: got %h want 0000", bus.mu_o); end
        vectors++;
        if (bus.clamp_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_clamp: got %b want 0", bus.clamp_o); end
    endtask

    // ctrl=0: strobe every 4th sample, mu=FFFF, sym 1,0,1...
    task automatic test_nominal();
        logic expSym;
        logic expStrobe;
        doReset();
        expSym = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 1'b0, 0);
            expStrobe = ((i % 4) == 0);
            vectors++;
            if (bus.strobe_o !== expStrobe) begin miscompares++; $display("[TB] FAIL nominal_strobe[%0d]: got %b want %b", i, bus.strobe_o, expStrobe); end
            vectors++;
            if (bus.clamp_o !== 1'b0) begin miscompares++; $display("[TB] FAIL nominal_clamp[%0d]: got %b want 0", i, bus.clamp_o); end
            if (expStrobe) begin
                vectors++;
                if (bus.mu_o !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL nominal_mu[%0d]: got %h want ffff", i, bus.mu_o); end
                vectors++;
                if (bus.sym_o !== expSym) begin miscompares++; $display("[TB] FAIL nominal_sym[%0d]: got %b want %b", i, bus.sym_o, expSym); end
                expSym = ~expSym;
            end
        end
    endtask

    // ctrl loaded in the same cycle as a sample: that sample still uses step 2^22
    task automatic test_ctrl_coincide();
        doReset();
        tick(1'b1, 1'b1, 8192);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick(1'b1, 1'b0, 0);
            vectors++;
            if (bus.strobe_o !== (i == 4)) begin miscompares++; $display("[TB] FAIL coincide_strobe[%0d]: got %b want %b", i, bus.strobe_o, (i == 4)); end
        end
        vectors++;
        if (bus.mu_o !== 16'hF7FF) begin miscompares++; $display("[TB] FAIL coincide_mu: got %h want f7ff", bus.mu_o); end
        vectors++;
        if (bus.sym_o !== 1'b1) begin miscompares++; $display("[TB] FAIL coincide_sym: got %b want 1", bus.sym_o); end
    endtask

    // ctrl=8192 (step 4259840) over 1000 samples: 253 strobes, intervals 3..4
    task automatic test_fast_ctrl();
        int   strobes;
        int   lastIdx;
        int   minInt;
        int   maxInt;
        logic expSym;
        doReset();
        tick(1'b0, 1'b1, 8192);
        strobes = 0;
        lastIdx = 0;
        minInt  = 1000;
        maxInt  = 0;
        expSym  = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            tick(1'b1, 1'b0, 0);
            if (bus.strobe_o === 1'b1) begin
                strobes++;
                vectors++;
                if (bus.sym_o !== expSym) begin miscompares++; $display("[TB] FAIL fast_sym[%0d]: got %b want %b", i, bus.sym_o, expSym); end
                expSym = ~expSym;
                if (lastIdx != 0) begin
                    if (i - lastIdx < minInt) minInt = i - lastIdx;
                    if (i - lastIdx > maxInt) maxInt = i - lastIdx;
                end
                lastIdx = i;
            end
        end
        vectors++;
        if (strobes != 253) begin miscompares++; $display("[TB] FAIL fast_count: got %0d want 253", strobes); end
        vectors++;
        if (minInt != 3) begin miscompares++; $display("[TB] FAIL fast_min_interval: got %0d want 3", minInt); end
        vectors++;
        if (maxInt != 4) begin miscompares++; $display("[TB] FAIL fast_max_interval: got %0d want 4", maxInt); end
    endtask

    // Large negative correction: clamped when enabled, otherwise clamp_o stays 0
    task automatic test_clamp();
`ifdef TIMING_NCO_CLAMP_EN
        int lastIdx;
        int firstIdx;
        int minInt;
        int maxInt;
        doReset();
        tick(1'b0, 1'b1, -131072);
        lastIdx  = 0;
        firstIdx = 0;
        minInt   = 1000;
        maxInt   = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b1, 1'b0, 0);
            vectors++;
            if (bus.clamp_o !== 1'b1) begin miscompares++; $display("[TB] FAIL clamp_flag[%0d]: got %b want 1", i, bus.clamp_o); end
            if (bus.strobe_o === 1'b1) begin
                if (firstIdx == 0) firstIdx = i;
                if (lastIdx != 0) begin
                    if (i - lastIdx < minInt) minInt = i - lastIdx;
                    if (i - lastIdx > maxInt) maxInt = i - lastIdx;
                end
                lastIdx = i;
            end
        end
        vectors++;
        if (firstIdx != 5) begin miscompares++; $display("[TB] FAIL clamp_first_strobe: got %0d want 5", firstIdx); end
        vectors++;
        if (minInt != 4) begin miscompares++; $display("[TB] FAIL clamp_min_interval: got %0d want 4", minInt); end
        vectors++;
        if (maxInt != 5) begin miscompares++; $display("[TB] FAIL clamp_max_interval: got %0d want 5", maxInt); end
`else
        doReset();
        tick(1'b0, 1'b1, -8192);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0, 0);
            vectors++;
            if (bus.clamp_o !== 1'b0) begin miscompares++; $display("[TB] FAIL noclamp_flag[%0d]: got %b want 0", i, bus.clamp_o); end
        end
`endif
    endtask

    // One-cycle reset mid-run clears outputs; next strobe 4 samples later with sym=1
    task automatic test_reset_mid();
        doReset();
        for (int i = 1; i <= 6; i++) tick(1'b1, 1'b0, 0);
        vectors++;
        if (bus.mu_o !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL mid_pre_mu: got %h want ffff", bus.mu_o); end
        reset = 1'b1;
        tick(1'b1, 1'b0, 0);
        reset = 1'b0;
        vectors++;
        if (bus.strobe_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_strobe: got %b want 0", bus.strobe_o); end
        vectors++;
        if (bus.mu_o !== 16'h0000) begin miscompares++; $display("[TB] FAIL mid_mu: got %h want 0000", bus.mu_o); end
        vectors++;
        if (bus.sym_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_sym: got %b want 0", bus.sym_o); end
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 1'b0, 0);
            vectors++;
            if (bus.strobe_o !== (i == 4)) begin miscompares++; $display("[TB] FAIL mid_post_strobe[%0d]: got %b want %b", i, bus.strobe_o, (i == 4)); end
        end
        vectors++;
        if (bus.sym_o !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_post_sym: got %b want 1", bus.sym_o); end
        vectors++;
        if (bus.mu_o !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL mid_post_mu: got %h want ffff", bus.mu_o); end
    endtask

    // One sample every 3 cycles: strobe every 12 cycles, state holds on idle cycles
    task automatic test_sparse();
        logic        expStrobe;
        logic        expSym;
        logic [15:0] expMu;
        int          samples;
        doReset();
        samples = 0;
        expSym  = 1'b0;
        expMu   = 16'h0000;
        for (int c = 0; c < 24; c++) begin
            expStrobe = 1'b0;
            if ((c % 3) == 0) begin
                samples++;
                if ((samples % 4) == 0) begin
                    expStrobe = 1'b1;
                    expSym    = ~expSym;
                    expMu     = 16'hFFFF;
                end
            end
            tick(((c % 3) == 0), 1'b0, 0);
            vectors++;
            if (bus.strobe_o !== expStrobe) begin miscompares++; $display("[TB] FAIL sparse_strobe[%0d]: got %b want %b", c, bus.strobe_o, expStrobe); end
            vectors++;
            if (bus.mu_o !== expMu) begin miscompares++; $display("[TB] FAIL sparse_mu[%0d]: got %h want %h", c, bus.mu_o, expMu); end
            vectors++;
            if (bus.sym_o !== expSym) begin miscompares++; $display("[TB] FAIL sparse_sym[%0d]: got %b want %b", c, bus.sym_o, expSym); end
        end
    endtask

    // Run all scenarios in sequence and report
    initial begin
        reset            = 1'b1;
        bus.sample_val_i = 1'b0;
        bus.ctrl_val_i   = 1'b0;
        bus.ctrl_i       = '0;
        $display("[TB] starting timing_nco bench");
        test_reset();
        test_nominal();
        test_ctrl_coincide();
        test_fast_ctrl();
        test_clamp();
        test_reset_mid();
        test_sparse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
